exec_datapath: RTL and testbench
================================

Name: exec_datapath

Overview:
- Execute/memory slice of the 16-bit single-cycle MIPS-style core: main decoder, 16-bit ALU with not-equal flag, 4-bit immediate sign-extension, word-addressed data memory and write-back mux.
- Sits between the register file (supplies two read operands, takes write-back data/address/enable) and the PC logic (takes branch_taken, jump, imm_ext).
- All logic is combinational except the data memory array.

Parameters:
- MEM_AW, 8, data memory address width; depth = 2**MEM_AW 16-bit words; only alu_result[MEM_AW-1:0] is used as the address.

Ports:
- clk  input  1  clock; memory writes occur on the rising edge.
- clr  input  1  asynchronous active-low reset; clears all data memory words.
- instr  input  16  current instruction; op=[15:12], fa=[11:8], fb=[7:4], fd=[3:0].
- reg_a_data  input  16  register file read data for fa.
- reg_b_data  input  16  register file read data for fb.
- reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump  output  1 each  decoded control signals.
- dest_addr  output  4  write-back register: fd if reg_dst=1, else fb.
- imm_ext  output  16  instr[3:0] sign-extended.
- alu_result  output  16  ALU result; also the memory address.
- ne  output  1  1 when alu_result != 0.
- branch_taken  output  1  branch AND ne.
- wb_data  output  16  mem_to_reg ? memory read data : alu_result.

Behaviour:
- ALU operands: X = reg_b_data; Y = alu_src ? imm_ext : reg_a_data.
- ALU op code = instr[15:12] directly. All arithmetic wraps mod 2^16; no carry or overflow outputs.
  - 0 AND: X&Y
  - 1 OR: X|Y
  - 2 ADD: X+Y
  - 3 SUB: X-Y
  - 4 SLT: signed, (X<Y) ? 1 : 0
  - 5 NOR: ~(X|Y)
  - 6 XOR: X^Y
  - 7 SLL: X<<Y[3:0]
  - 8 ADDI, 9 LW, A SW: X+Y
  - B BNE: X-Y
  - C J, D, E, F: result 0
- Decoder outputs, listed as reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump:
  - ops 0-7 (R-type): 1,0,0,1,0,0,0
  - 8 ADDI: 0,1,0,1,0,0,0
  - 9 LW: 0,1,1,1,0,0,0
  - A SW: 0,1,0,0,1,0,0
  - B BNE: 0,0,0,0,0,1,0
  - C J: 0,0,0,0,0,0,1
  - D-F: all 0 (NOP)
- Resulting instruction semantics:
  - ADDI: R[fb] = R[fb] + sext(fd).
  - LW: R[fb] = M[R[fb] + sext(fd)].
  - SW: M[R[fb] + sext(fd)] = reg_a_data (R[fa]).
  - BNE: taken when R[fb] != R[fa].
- Data memory:
  - Read is combinational from alu_result[MEM_AW-1:0].
  - Write happens at posedge clk when mem_write=1; write data = reg_a_data.
  - Upper address bits are ignored, so addresses alias (wrap modulo depth).
- Reset:
  - clr=0 clears every memory word to 0 immediately, independent of clk; writes are blocked while clr=0.
  - Reset asserted between edges takes effect at once, and reads return 0 after reset.
  - Combinational outputs have no reset value; they always follow instr and the operands.
- Read-during-write: the same-cycle read returns the old word; the new value is visible after the edge.
- No handshake; one instruction per clock, zero-cycle combinational latency.

Test Plan:
- Reset then LW: clr=0 pulse, then instr=0x9000, reg_b=5 -> wb_data=0, reg_write=1, mem_to_reg=1, dest_addr=0.
- SW then LW:
  - instr=0xA12F, reg_b=0x0011, reg_a=0xBEEF, clock edge -> mem[0x10]=0xBEEF.
  - Then instr=0x9120, reg_b=0x0010 -> wb_data=0xBEEF.
- ALU ops:
  - ADD 0x7FFF+1 -> 0x8000.
  - SUB 0-1 -> 0xFFFF.
  - SLT 0xFFFF<1 -> 1.
  - SLL 0x0003 by 4 -> 0x0030.
  - NOR 0,0 -> 0xFFFF.
- ADDI sign extension: instr=0x8018, reg_b=10 -> imm_ext=0xFFF8, alu_result=2, dest_addr=1, alu_src=1.
- BNE:
  - instr=0xB123, reg_b=reg_a=7 -> ne=0, branch_taken=0.
  - reg_a=8 -> branch_taken=1.
  - J (0xC123) -> jump=1, branch_taken=0, reg_write=0.
- Address wrap and async reset:
  - SW to alu_result=0x0105 with MEM_AW=8 -> LW from 0x0005 returns the stored value.
  - Drop clr mid-cycle -> read returns 0 before the next clock edge.

Source files
------------

// File: rtl/exec_datapath.sv
// exec_datapath: execute/memory slice of the 16-bit single-cycle core.
// Main decoder, ALU with not-equal flag, 4-bit immediate sign extension,
// word-addressed data memory and write-back select. Only the data memory
// holds state; every other output follows instr and the operands directly.
module exec_datapath #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] instr,
  input  logic [15:0] reg_a_data,
  input  logic [15:0] reg_b_data,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [3:0]  dest_addr,
  output logic [15:0] imm_ext,
  output logic [15:0] alu_result,
  output logic        ne,
  output logic        branch_taken,
  output logic [15:0] wb_data
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;

  logic [3:0] op;
  logic [3:0] fb;
  logic [3:0] fd;
  logic       unused_fa;

  assign op = instr[15:12];
  assign fb = instr[7:4];
  assign fd = instr[3:0];
  // fa only selects the register-file read port upstream; reg_a_data carries its value.
  assign unused_fa = ^instr[11:8];

  // Main decoder: control bits from the opcode; D-F fall through as NOP.
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR, OP_SLL: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BNE: branch = 1'b1;
      OP_J:   jump   = 1'b1;
      default: ;
    endcase
  end

  assign imm_ext   = {{(DATA_W - 4){fd[3]}}, fd};
  assign dest_addr = reg_dst ? fd : fb;

  logic        [DATA_W-1:0] alu_x;
  logic        [DATA_W-1:0] alu_y;
  logic signed [DATA_W-1:0] alu_xs;
  logic signed [DATA_W-1:0] alu_ys;

  assign alu_x  = reg_b_data;
  assign alu_y  = alu_src ? imm_ext : reg_a_data;
  assign alu_xs = alu_x;
  assign alu_ys = alu_y;

  // ALU: opcode selects the operation directly; everything wraps mod 2^16.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_AND:                  alu_result = alu_x & alu_y;
      OP_OR:                   alu_result = alu_x | alu_y;
      OP_ADD, OP_ADDI,
      OP_LW, OP_SW:            alu_result = alu_x + alu_y;
      OP_SUB, OP_BNE:          alu_result = alu_x - alu_y;
      OP_SLT:                  alu_result = (alu_xs < alu_ys) ? 16'd1 : 16'd0;
      OP_NOR:                  alu_result = ~(alu_x | alu_y);
      OP_XOR:                  alu_result = alu_x ^ alu_y;
      OP_SLL:                  alu_result = alu_x << alu_y[3:0];
      default:                 alu_result = '0;
    endcase
  end

  assign ne           = |alu_result;
  assign branch_taken = branch & ne;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Upper address bits are dropped, so addresses alias modulo the depth.
  assign mem_addr  = alu_result[MEM_AW-1:0];
  assign mem_rdata = mem[mem_addr];

  // Data memory: clr wipes every word at once; otherwise SW writes on the edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[mem_addr] <= reg_a_data;
    end
  end

  assign wb_data = mem_to_reg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath with an expectation queue: each step
// pushes its expected outputs when it drives the inputs, then drains the
// queue against the DUT once the combinational outputs have settled.
module tb_exec_datapath;

  logic        clk;
  logic        clr;
  logic [15:0] instr;
  logic [15:0] reg_a_data;
  logic [15:0] reg_b_data;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump;
  logic [3:0]  dest_addr;
  logic [15:0] imm_ext;
  logic [15:0] alu_result;
  logic        ne;
  logic        branch_taken;
  logic [15:0] wb_data;

  exec_datapath #(.MEM_AW(8)) dut (
    .clk          (clk),
    .clr          (clr),
    .instr        (instr),
    .reg_a_data   (reg_a_data),
    .reg_b_data   (reg_b_data),
    .reg_dst      (reg_dst),
    .alu_src      (alu_src),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .branch       (branch),
    .jump         (jump),
    .dest_addr    (dest_addr),
    .imm_ext      (imm_ext),
    .alu_result   (alu_result),
    .ne           (ne),
    .branch_taken (branch_taken),
    .wb_data      (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_WB   = 0;
  localparam int S_ALU  = 1;
  localparam int S_IMM  = 2;
  localparam int S_DEST = 3;
  localparam int S_NE   = 4;
  localparam int S_BT   = 5;
  localparam int S_CTRL = 6;

  // control vector order: reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump
  localparam logic [15:0] C_R    = 16'b1001000;
  localparam logic [15:0] C_ADDI = 16'b0101000;
  localparam logic [15:0] C_LW   = 16'b0111000;
  localparam logic [15:0] C_SW   = 16'b0100100;
  localparam logic [15:0] C_BNE  = 16'b0000010;
  localparam logic [15:0] C_J    = 16'b0000001;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      S_WB:    return wb_data;
      S_ALU:   return alu_result;
      S_IMM:   return imm_ext;
      S_DEST:  return {12'b0, dest_addr};
      S_NE:    return {15'b0, ne};
      S_BT:    return {15'b0, branch_taken};
      S_CTRL:  return {9'b0, reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Independent reference for the R-type ALU ops (X = reg_b, Y = reg_a).
  function automatic logic [15:0] model_r(input logic [3:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
    case (op)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return 16'(x + y);
      4'h3: return 16'(x - y);
      4'h4: return ($signed(x) < $signed(y)) ? 16'h0001 : 16'h0000;
      4'h5: return ~(x | y);
      4'h6: return x ^ y;
      default: return 16'(x << y[3:0]);
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic apply(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    instr      = i;
    reg_a_data = a;
    reg_b_data = b;
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    clr        = 1'b0;
    instr      = 16'hD000;
    reg_a_data = 16'h0000;
    reg_b_data = 16'h0000;

    // SW while clr is low must not land
    apply(16'hA000, 16'hAAAA, 16'h0005);
    apply(16'h9000, 16'h0000, 16'h0005);
    push("lw_in_reset", S_WB, 16'h0000);
    drain();
    clr = 1'b1;

    // Reset then LW
    apply(16'h9000, 16'h0000, 16'h0005);
    push("rst_lw_wb", S_WB, 16'h0000);
    push("rst_lw_ctrl", S_CTRL, C_LW);
    push("rst_lw_dest", S_DEST, 16'h0000);
    push("rst_lw_alu", S_ALU, 16'h0005);
    drain();

    // SW then LW (imm -1)
    apply(16'hA12F, 16'hBEEF, 16'h0011);
    push("sw_imm", S_IMM, 16'hFFFF);
    push("sw_alu", S_ALU, 16'h0010);
    push("sw_ctrl", S_CTRL, C_SW);
    drain();
    apply(16'h9120, 16'h0000, 16'h0010);
    push("lw_beef", S_WB, 16'hBEEF);
    push("lw_dest", S_DEST, 16'h0002);
    drain();

    // ALU corner cases
    apply(16'h2000, 16'h0001, 16'h7FFF);
    push("add_wrap", S_ALU, 16'h8000);
    push("add_ctrl", S_CTRL, C_R);
    push("add_wb", S_WB, 16'h8000);
    drain();
    apply(16'h3005, 16'h0001, 16'h0000);
    push("sub_neg", S_ALU, 16'hFFFF);
    push("sub_dest", S_DEST, 16'h0005);
    drain();
    apply(16'h4000, 16'h0001, 16'hFFFF);
    push("slt_signed", S_ALU, 16'h0001);
    drain();
    apply(16'h4000, 16'hFFFF, 16'h0001);
    push("slt_false", S_ALU, 16'h0000);
    drain();
    apply(16'h7000, 16'h0004, 16'h0003);
    push("sll_4", S_ALU, 16'h0030);
    drain();
    apply(16'h5000, 16'h0000, 16'h0000);
    push("nor_zero", S_ALU, 16'hFFFF);
    drain();

    // Random R-type sweep against the reference model
    for (int k = 0; k < 16; k++) begin
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 4'(k % 8);
      a  = 16'($urandom);
      b  = 16'($urandom);
      apply({op, 12'h000}, a, b);
      push("r_rand", S_ALU, model_r(op, b, a));
      drain();
    end

    // ADDI sign extension
    apply(16'h8018, 16'h0000, 16'h000A);
    push("addi_imm", S_IMM, 16'hFFF8);
    push("addi_alu", S_ALU, 16'h0002);
    push("addi_dest", S_DEST, 16'h0001);
    push("addi_ctrl", S_CTRL, C_ADDI);
    drain();

    // BNE / J
    apply(16'hB123, 16'h0007, 16'h0007);
    push("bne_eq_ne", S_NE, 16'h0000);
    push("bne_eq_bt", S_BT, 16'h0000);
    push("bne_ctrl", S_CTRL, C_BNE);
    drain();
    apply(16'hB123, 16'h0008, 16'h0007);
    push("bne_ne_ne", S_NE, 16'h0001);
    push("bne_ne_bt", S_BT, 16'h0001);
    drain();
    apply(16'hC123, 16'h0008, 16'h0007);
    push("j_ctrl", S_CTRL, C_J);
    push("j_bt", S_BT, 16'h0000);
    push("j_alu", S_ALU, 16'h0000);
    drain();
    apply(16'hE123, 16'h0008, 16'h0007);
    push("nop_ctrl", S_CTRL, 16'h0000);
    drain();

    // Address wrap: 0x0105 aliases to word 5
    apply(16'hA000, 16'h1234, 16'h0105);
    push("wrap_sw_alu", S_ALU, 16'h0105);
    drain();
    apply(16'h9000, 16'h0000, 16'h0005);
    push("wrap_lw", S_WB, 16'h1234);
    drain();

    // Mid-cycle clear: read goes to 0 before the next edge
    #1 clr = 1'b0;
    #1;
    push("async_clr", S_WB, 16'h0000);
    drain();
    clr = 1'b1;
    apply(16'h9000, 16'h0000, 16'h0005);
    push("after_clr", S_WB, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
